lsu_ctrl: RTL and testbench

Load/store unit placed directly upstream of the data memory. It accepts one load or store request at a time from the execute stage through a valid/ready handshake and checks alignment and address range. Accepted requests become registered word-addressed byte-enabled memory accesses. Load data is extracted and sign- or zero-extended, then returned through a second valid/ready handshake.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_ctrl.sv | 129 ++++++++++++
 tb/tb_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, exception codes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP,
    ST_EXC
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, misalignment
// detection on the incoming request, and load-lane extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  chk_size_i,
  input  logic [1:0]  chk_lo_i,
  output logic        misaligned_o,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Size 2'b11 falls into the word rules everywhere below.
  assign misaligned_o = ((chk_size_i == SZ_HALF) && chk_lo_i[0]) ||
                        ((chk_size_i != SZ_HALF) && (chk_size_i != SZ_BYTE) &&
                         (chk_lo_i != 2'b00));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = rdata_i[7:0];
    case (lo_i)
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      2'd3:    lane_b = rdata_i[31:24];
      default: ;
    endcase
    lane_h = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ldata_o = rdata_i;
    case (size_i)
      SZ_BYTE: ldata_o = {{24{~uns_i & lane_b[7]}}, lane_b};
      SZ_HALF: ldata_o = {{16{~uns_i & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a synchronous data memory: request latch, FSM and
// response register. Define LSU_STORE_LOG_EN to print every store in simulation.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_rd,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_pc,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_addr
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q, resp_data_q;
  logic [4:0]  rd_q;

  logic        misaligned, fault, issue;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ld_data;

  lsu_align u_align (
    .chk_size_i   (req_size),
    .chk_lo_i     (req_addr[1:0]),
    .misaligned_o (misaligned),
    .size_i       (size_q),
    .lo_i         (addr_q[1:0]),
    .uns_i        (uns_q),
    .wdata_i      (wdata_q),
    .rdata_i      (mem_rdata),
    .be_o         (be),
    .wdata_o      (wdata_rep),
    .ldata_o      (ld_data)
  );

  // Full 33-bit compare so addresses near 2^32 cannot wrap into range.
  assign fault = misaligned || ({1'b0, req_addr} >= ADDR_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = fault ? ST_EXC : ST_ISSUE;
      ST_ISSUE:   state_d = we_q ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_WORD;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
        rd_q    <= req_rd;
      end
      if (state_q == ST_CAPTURE) resp_data_q <= ld_data;
    end
  end

  assign issue     = (state_q == ST_ISSUE);
  assign req_ready = (state_q == ST_IDLE);
  assign mem_en    = issue;
  assign mem_we    = issue & we_q;
  assign mem_be    = issue ? be : 4'b0000;
  assign mem_addr  = issue ? addr_q[31:2] : 30'd0;
  assign mem_wdata = issue ? wdata_rep : 32'd0;

  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_valid ? rd_q : 5'd0;
  assign resp_pc    = resp_valid ? pc_q : 32'd0;

  assign exc_valid = (state_q == ST_EXC);
  assign exc_code  = exc_valid ? (we_q ? EXC_ADES : EXC_ADEL) : 5'd0;
  assign exc_addr  = exc_valid ? addr_q : 32'd0;

`ifdef LSU_STORE_LOG_EN
  logic [31:0] log_mask;
  assign log_mask = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};

  always @(posedge clk) begin
    if (reset && mem_we)
      $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, mem_wdata & log_mask);
  end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a small synchronous memory model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [4:0]  req_rd;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data, resp_pc;
  logic [4:0]  resp_rd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_addr;

  logic        poke_en = 1'b0;
  logic [11:0] poke_idx = 12'd0;
  logic [31:0] poke_data = 32'd0;
  logic [31:0] mem [0:3071];

  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.DEPTH_WORDS(3072)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .req_rd       (req_rd),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_rd      (resp_rd),
    .resp_pc      (resp_pc),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_addr     (exc_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end else if (mem_en && mem_we && mem_addr < 30'd3072) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_en && !mem_we && mem_addr < 30'd3072) mem_rdata <= mem[mem_addr[11:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] idx, input logic [31:0] data);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_pc = pc; req_rd = rd;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    check({tag, " idle rdy"}, 32'(req_ready), 1);
    set_req(1'b0, size, uns, addr, 32'hDEAD_BEEF, pc, rd);
    tick();
    req_valid = 1'b0;
    check({tag, " T1 en"},   32'(mem_en), 1);
    check({tag, " T1 we"},   32'(mem_we), 0);
    check({tag, " T1 addr"}, 32'(mem_addr), {2'b00, addr[31:2]});
    check({tag, " T1 be"},   32'(mem_be), {28'd0, exp_be});
    check({tag, " T1 rdy"},  32'(req_ready), 0);
    tick();
    check({tag, " T2 en"},   32'(mem_en), 0);
    check({tag, " T2 vld"},  32'(resp_valid), 0);
    tick();
    check({tag, " T3 vld"},  32'(resp_valid), 1);
    check({tag, " T3 data"}, resp_data, exp_data);
    check({tag, " T3 rd"},   32'(resp_rd), {27'd0, rd});
    check({tag, " T3 pc"},   resp_pc, pc);
    tick();
    check({tag, " T4 vld"},  32'(resp_valid), 0);
    check({tag, " T4 rdy"},  32'(req_ready), 1);
  endtask

  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    set_req(1'b1, size, 1'b0, addr, wdata, pc, 5'd0);
    tick();
    req_valid = 1'b0;
    check({tag, " T1 en"},    32'(mem_en), 1);
    check({tag, " T1 we"},    32'(mem_we), 1);
    check({tag, " T1 be"},    32'(mem_be), {28'd0, exp_be});
    check({tag, " T1 addr"},  32'(mem_addr), {2'b00, addr[31:2]});
    check({tag, " T1 wdata"}, mem_wdata, exp_wdata);
    check({tag, " T1 rdy"},   32'(req_ready), 0);
    tick();
    check({tag, " T2 rdy"},   32'(req_ready), 1);
    check({tag, " T2 en"},    32'(mem_en), 0);
  endtask

  task automatic do_exc(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [4:0] exp_code);
    set_req(we, size, 1'b0, addr, 32'h1111_2222, 32'h0000_4000, 5'd1);
    tick();
    req_valid = 1'b0;
    check({tag, " T1 exc"},  32'(exc_valid), 1);
    check({tag, " T1 code"}, 32'(exc_code), {27'd0, exp_code});
    check({tag, " T1 addr"}, exc_addr, addr);
    check({tag, " T1 en"},   32'(mem_en), 0);
    check({tag, " T1 rdy"},  32'(req_ready), 0);
    tick();
    check({tag, " T2 exc"},  32'(exc_valid), 0);
    check({tag, " T2 en"},   32'(mem_en), 0);
    check({tag, " T2 rdy"},  32'(req_ready), 1);
  endtask

  initial begin
    reset = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0; req_rd = '0;

    poke(12'd1, 32'h8000_FF7F);
    poke(12'd3071, 32'h1234_5678);
    tick();
    check("rst rdy",  32'(req_ready), 1);
    check("rst en",   32'(mem_en), 0);
    check("rst vld",  32'(resp_valid), 0);
    check("rst exc",  32'(exc_valid), 0);
    check("rst data", resp_data, 32'h0);
    reset = 1'b1;

    do_load("lb s", SZ_BYTE, 1'b0, 32'h5, 32'h0000_1000, 5'd3, 4'b0010, 32'hFFFF_FFFF);
    do_load("lb u", SZ_BYTE, 1'b1, 32'h5, 32'h0000_1004, 5'd4, 4'b0010, 32'h0000_00FF);
    do_load("lh lo", SZ_HALF, 1'b0, 32'h4, 32'h0000_1008, 5'd5, 4'b0011, 32'hFFFF_FF7F);
    do_load("lw top", SZ_WORD, 1'b0, 32'h2FFC, 32'h0000_100C, 5'd6, 4'b1111, 32'h1234_5678);

    do_exc("lh mis", 1'b0, SZ_HALF, 32'h3, EXC_ADEL);
    do_exc("sw mis", 1'b1, SZ_WORD, 32'h2, EXC_ADES);
    do_exc("lw oor", 1'b0, SZ_WORD, 32'h3000, EXC_ADEL);
    do_exc("lb high", 1'b0, SZ_BYTE, 32'hFFFF_FFFF, EXC_ADEL);

    // Backpressure: result held while a new request waits.
    resp_ready = 1'b0;
    set_req(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, 32'h0000_2000, 5'd7);
    tick();
    set_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h0000_2004, 5'd9);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp vld",  32'(resp_valid), 1);
      check("bp data", resp_data, 32'h0000_8000);
      check("bp rd",   32'(resp_rd), 7);
      check("bp rdy",  32'(req_ready), 0);
      tick();
    end
    resp_ready = 1'b1;
    check("bp last vld", 32'(resp_valid), 1);
    tick();
    check("bp idle rdy", 32'(req_ready), 1);
    check("bp idle vld", 32'(resp_valid), 0);
    tick();
    req_valid = 1'b0;
    check("bp next en",   32'(mem_en), 1);
    check("bp next addr", 32'(mem_addr), 1);
    tick();
    tick();
    check("bp next data", resp_data, 32'h8000_FF7F);
    check("bp next rd",   32'(resp_rd), 9);
    tick();

    do_store("sb", SZ_BYTE, 32'h6, 32'h0000_00AB, 32'h0000_3000, 4'b0100, 32'hABAB_ABAB);
    do_store("sh", SZ_HALF, 32'h2FFE, 32'h5555_BEEF, 32'h0000_3004, 4'b1100, 32'hBEEF_BEEF);
    do_load("lh rb", SZ_HALF, 1'b0, 32'h6, 32'h0000_3008, 5'd10, 4'b1100, 32'hFFFF_80AB);
    do_load("lw rb", SZ_WORD, 1'b0, 32'h2FFC, 32'h0000_300C, 5'd11, 4'b1111, 32'hBEEF_5678);

    // Reset while a load sits in CAPTURE drops its result.
    set_req(1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0, 32'h0000_5000, 5'd12);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst cap vld", 32'(resp_valid), 0);
    check("rst cap rdy", 32'(req_ready), 1);
    check("rst cap en",  32'(mem_en), 0);
    tick();
    check("rst cap vld2", 32'(resp_valid), 0);
    tick();
    check("rst cap vld3", 32'(resp_valid), 0);

    do_load("post rst", SZ_BYTE, 1'b1, 32'h7, 32'h0000_6000, 5'd13, 4'b1000, 32'h0000_0080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
